mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 159 +++++++++++++++
 tb/tb_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-word memory responder: word RAM, LED register, cycle counter, address decode.
// Optional wait states are built when MEM_WAIT_STATE_EN is defined.
module mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 2,
   parameter int LED_W       = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      i_mem_addr,
   input  logic             i_mem_rd,
   input  logic             i_mem_wr,
   input  logic [15:0]      i_mem_wrdata,
   output logic [15:0]      o_mem_rddata,
   output logic             o_rd_valid,
   output logic             o_busy,
   output logic             o_addr_err,
   output logic [LED_W-1:0] o_ledr
);

   localparam int DEPTH = 2**ADDR_W;

   logic [15:0]      mem_q [DEPTH];
   logic [15:0]      rddata_q;
   logic             rd_valid_q;
   logic             addr_err_q;
   logic [LED_W-1:0] led_q;
   logic [15:0]      cyc_q;
   logic [15:0]      cyc_d;

   logic             busy;
   logic             accept;
   logic             acc_go;
   logic             acc_wr;
   logic [15:0]      acc_addr;
   logic [15:0]      acc_wrdata;

   assign accept = !busy && (i_mem_rd || i_mem_wr);

`ifdef MEM_WAIT_STATE_EN
   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [15:0] lat_addr_q;
   logic [15:0] lat_wrdata_q;
   logic        lat_wr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         wcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // A simultaneous rd+wr is latched as a write.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_addr_q   <= i_mem_addr;
         lat_wrdata_q <= i_mem_wrdata;
         lat_wr_q     <= i_mem_wr;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_WAIT;
               wcnt_d  = 4'(WAIT_STATES - 1);
            end
         end
         S_WAIT: begin
            if (wcnt_q == 4'd0) state_d = S_IDLE;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q == S_WAIT);
      acc_go = (state_q == S_WAIT) && (wcnt_q == 4'd0);
   end

   assign acc_addr   = lat_addr_q;
   assign acc_wr     = lat_wr_q;
   assign acc_wrdata = lat_wrdata_q;
`else
   logic [3:0] unused_wait_states;

   assign unused_wait_states = 4'(WAIT_STATES);
   assign busy       = 1'b0;
   assign acc_go     = accept;
   assign acc_addr   = i_mem_addr;
   assign acc_wr     = i_mem_wr;
   assign acc_wrdata = i_mem_wrdata;
`endif

   logic              hit_ram, hit_led, hit_cyc, unmapped;
   logic [ADDR_W-1:0] ram_idx;
   logic [15:0]       led_ext;
   logic [15:0]       rd_word;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = acc_addr[0];
   assign hit_ram  = (acc_addr[15:ADDR_W+1] == '0);
   assign hit_led  = (acc_addr[15:1] == 15'h7F80);
   assign hit_cyc  = (acc_addr[15:1] == 15'h7F81);
   assign unmapped = !(hit_ram || hit_led || hit_cyc);
   assign ram_idx  = acc_addr[ADDR_W:1];
   assign cyc_d    = cyc_q + 16'd1;

   // A counter read returns the value the counter takes at the completion edge.
   always_comb begin
      led_ext = 16'h0000;
      led_ext[LED_W-1:0] = led_q;
      rd_word = 16'h0000;
      if (hit_ram)      rd_word = mem_q[ram_idx];
      else if (hit_led) rd_word = led_ext;
      else if (hit_cyc) rd_word = cyc_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rddata_q   <= 16'h0000;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
         led_q      <= '0;
         cyc_q      <= 16'h0000;
      end else begin
         cyc_q      <= cyc_d;
         rd_valid_q <= acc_go && !acc_wr;
         addr_err_q <= acc_go && unmapped;
         if (acc_go && !acc_wr)
            rddata_q <= rd_word;
         if (acc_go && acc_wr && hit_led)
            led_q <= acc_wrdata[LED_W-1:0];
      end
   end

   // RAM has no reset; reset still suppresses a pending write.
   always_ff @(posedge clk) begin
      if (!reset && acc_go && acc_wr && hit_ram)
         mem_q[ram_idx] <= acc_wrdata;
   end

   assign o_mem_rddata = rddata_q;
   assign o_rd_valid   = rd_valid_q;
   assign o_addr_err   = addr_err_q;
   assign o_busy       = busy;
   assign o_ledr       = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder.
// Wait-state checks are built when MEM_WAIT_STATE_EN is defined.
module tb_mem_responder;

   localparam int ADDR_W = 8;
   localparam int W      = 2;
   localparam int LED_W  = 10;

   logic             clk = 1'b0;
   logic             reset;
   logic [15:0]      i_mem_addr;
   logic             i_mem_rd;
   logic             i_mem_wr;
   logic [15:0]      i_mem_wrdata;
   logic [15:0]      o_mem_rddata;
   logic             o_rd_valid;
   logic             o_busy;
   logic             o_addr_err;
   logic [LED_W-1:0] o_ledr;

   int tests = 0;
   int fails = 0;
   int edges = 0;

   mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(W), .LED_W(LED_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_mem_addr   (i_mem_addr),
      .i_mem_rd     (i_mem_rd),
      .i_mem_wr     (i_mem_wr),
      .i_mem_wrdata (i_mem_wrdata),
      .o_mem_rddata (o_mem_rddata),
      .o_rd_valid   (o_rd_valid),
      .o_busy       (o_busy),
      .o_addr_err   (o_addr_err),
      .o_ledr       (o_ledr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic req(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data);
      i_mem_rd     = rd;
      i_mem_wr     = wr;
      i_mem_addr   = addr;
      i_mem_wrdata = data;
      step();
      i_mem_rd     = 1'b0;
      i_mem_wr     = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      i_mem_addr = 16'h0; i_mem_rd = 1'b0; i_mem_wr = 1'b0; i_mem_wrdata = 16'h0;
      step();
      step();
      chk("rst_rddata", o_mem_rddata, 16'h0000);
      chk("rst_rd_valid", 16'(o_rd_valid), 16'h0);
      chk("rst_busy", 16'(o_busy), 16'h0);
      chk("rst_addr_err", 16'(o_addr_err), 16'h0);
      chk("rst_ledr", 16'(o_ledr), 16'h0000);
      reset = 1'b0;
      edges = 0;

`ifdef MEM_WAIT_STATE_EN
      req(1'b0, 1'b1, 16'h0010, 16'h1234);
      chk("w_busy_e0", 16'(o_busy), 16'h1);
      step();
      chk("w_busy_e1", 16'(o_busy), 16'h1);
      step();
      chk("w_busy_e2", 16'(o_busy), 16'h0);
      chk("w_no_rdv", 16'(o_rd_valid), 16'h0);
      req(1'b1, 1'b0, 16'h0010, 16'h0000);
      chk("r_busy_e0", 16'(o_busy), 16'h1);
      chk("r_rdv_e0", 16'(o_rd_valid), 16'h0);
      req(1'b1, 1'b0, 16'h0020, 16'h0000);
      chk("r_busy_e1", 16'(o_busy), 16'h1);
      step();
      chk("r_busy_e2", 16'(o_busy), 16'h0);
      chk("r_rdv_e2", 16'(o_rd_valid), 16'h1);
      chk("r_data_e2", o_mem_rddata, 16'h1234);
      step();
      chk("dropped_rdv", 16'(o_rd_valid), 16'h0);
      chk("dropped_busy", 16'(o_busy), 16'h0);
      req(1'b0, 1'b1, 16'hFF00, 16'h03FF); step(); step();
      chk("w_led", 16'(o_ledr), 16'h03FF);
      req(1'b0, 1'b1, 16'h0004, 16'h1111); step(); step();
      req(1'b0, 1'b1, 16'h0004, 16'h5555);
      chk("rstw_busy", 16'(o_busy), 16'h1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rstw_busy0", 16'(o_busy), 16'h0);
      chk("rstw_rdv", 16'(o_rd_valid), 16'h0);
      chk("rstw_rddata", o_mem_rddata, 16'h0000);
      chk("rstw_ledr", 16'(o_ledr), 16'h0000);
      req(1'b1, 1'b0, 16'h0004, 16'h0000); step(); step();
      chk("rstw_rdv2", 16'(o_rd_valid), 16'h1);
      chk("rstw_keep", o_mem_rddata, 16'h1111);
`else
      step(); step(); step(); step();
      req(1'b1, 1'b0, 16'hFF02, 16'h0000);
      chk("cyc_5", o_mem_rddata, 16'h0005);
      chk("cyc_rdv", 16'(o_rd_valid), 16'h1);

      req(1'b0, 1'b1, 16'h0010, 16'h1234);
      chk("wr_rdv", 16'(o_rd_valid), 16'h0);
      chk("wr_err", 16'(o_addr_err), 16'h0);
      chk("wr_hold", o_mem_rddata, 16'h0005);
      req(1'b1, 1'b0, 16'h0010, 16'h0000);
      chk("rd_rdv", 16'(o_rd_valid), 16'h1);
      chk("rd_data", o_mem_rddata, 16'h1234);
      chk("rd_busy", 16'(o_busy), 16'h0);
      step();
      chk("idle_rdv", 16'(o_rd_valid), 16'h0);
      chk("idle_hold", o_mem_rddata, 16'h1234);

      req(1'b0, 1'b1, 16'hFF00, 16'hFFFF);
      chk("led_w", 16'(o_ledr), 16'h03FF);
      req(1'b1, 1'b0, 16'hFF00, 16'h0000);
      chk("led_r", o_mem_rddata, 16'h03FF);
      req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
      req(1'b1, 1'b0, 16'h0011, 16'h0000);
      chk("odd_addr", o_mem_rddata, 16'hBEEF);

      req(1'b1, 1'b1, 16'h0020, 16'hA5A5);
      chk("rdwr_rdv", 16'(o_rd_valid), 16'h0);
      req(1'b1, 1'b0, 16'h0020, 16'h0000);
      chk("rdwr_data", o_mem_rddata, 16'hA5A5);

      req(1'b1, 1'b0, 16'h8000, 16'h0000);
      chk("bad_r_data", o_mem_rddata, 16'h0000);
      chk("bad_r_rdv", 16'(o_rd_valid), 16'h1);
      chk("bad_r_err", 16'(o_addr_err), 16'h1);
      step();
      chk("bad_r_err_end", 16'(o_addr_err), 16'h0);
      req(1'b0, 1'b1, 16'h0000, 16'h1111);
      req(1'b0, 1'b1, 16'h8000, 16'h2222);
      chk("bad_w_err", 16'(o_addr_err), 16'h1);
      chk("bad_w_rdv", 16'(o_rd_valid), 16'h0);
      req(1'b1, 1'b0, 16'h0000, 16'h0000);
      chk("bad_w_ram", o_mem_rddata, 16'h1111);

      req(1'b0, 1'b1, 16'h01FE, 16'h7E7E);
      req(1'b1, 1'b0, 16'h01FF, 16'h0000);
      chk("ram_top", o_mem_rddata, 16'h7E7E);
      req(1'b1, 1'b0, 16'h0200, 16'h0000);
      chk("ram_end_err", 16'(o_addr_err), 16'h1);
      chk("ram_end_data", o_mem_rddata, 16'h0000);
      req(1'b0, 1'b1, 16'hFF02, 16'h1234);
      chk("cyc_w_err", 16'(o_addr_err), 16'h0);
      req(1'b0, 1'b1, 16'hFF01, 16'h0001);
      chk("led_odd", 16'(o_ledr), 16'h0001);

      while (edges < 65534) step();
      req(1'b1, 1'b0, 16'hFF02, 16'h0000);
      chk("cyc_ffff", o_mem_rddata, 16'hFFFF);
      req(1'b1, 1'b0, 16'hFF02, 16'h0000);
      chk("cyc_wrap", o_mem_rddata, 16'h0000);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
